// File: rtl/alu_op_issuer_if.sv
// Request port between the CCU control sequencer (master) and the ALU operation issuer (slave).
// Carries one ALU operation per valid/ready handshake.
interface alu_op_issuer_if #(
  parameter int IDX_W = 2
) ();
  logic             req_valid;
  logic             req_ready;
  logic [3:0]       req_op;
  logic [IDX_W-1:0] req_sa;
  logic [IDX_W-1:0] req_sb;
  logic [IDX_W-1:0] req_dst;

  modport master (
    output req_valid,
    output req_op,
    output req_sa,
    output req_sb,
    output req_dst,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_op,
    input  req_sa,
    input  req_sb,
    input  req_dst,
    output req_ready
  );
endinterface

// File: rtl/alu_op_issuer.sv
// Initiator side of the CCU ALU interface: register file, operand issue, result writeback, CC register.
// Optional macro BACK_TO_BACK_EN: accept during EXEC (1 op/cycle) with result forwarding to operands.
module alu_op_issuer #(
  parameter int NREGS = 4,
  parameter int IDX_W = 2
) (
  input  logic              clk,
  input  logic              reset,
  alu_op_issuer_if.slave    req,
  input  logic              ld_en,
  input  logic [IDX_W-1:0]  ld_idx,
  input  logic [7:0]        ld_data,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic [7:0]        rd_data,
  output logic [7:0]        alu_a,
  output logic [7:0]        alu_b,
  output logic [3:0]        alu_n,
  input  logic [7:0]        alu_r,
  input  logic [3:0]        alu_cc,
  input  logic              alu_we,
  output logic              done_valid,
  output logic [7:0]        done_r,
  output logic              done_err,
  output logic [3:0]        cc_q
);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_EXEC = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             w_ready;
  logic             w_accept;
  logic             w_wb;
  logic [7:0]       w_opa;
  logic [7:0]       w_opb;

  logic [7:0]       r_regs [NREGS];
  logic [IDX_W-1:0] r_dst;
  logic             r_illegal;
  logic [7:0]       r_alu_a;
  logic [7:0]       r_alu_b;
  logic [3:0]       r_alu_n;
  logic             r_done_valid;
  logic [7:0]       r_done_r;
  logic             r_done_err;
  logic [3:0]       r_cc_q;

  // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_ready     = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_ready = 1'b1;
        if (req.req_valid) w_state_nxt = S_EXEC;
      end
      S_EXEC: begin
`ifdef BACK_TO_BACK_EN
        w_ready     = 1'b1;
        w_state_nxt = req.req_valid ? S_EXEC : S_IDLE;
`else
        w_ready     = 1'b0;
        w_state_nxt = S_IDLE;
`endif
      end
    endcase
  end

  assign req.req_ready = w_ready;
  assign w_accept      = req.req_valid & w_ready;
  // Writeback happens on the edge that ends EXEC, for legal ops the ALU asks to write.
  assign w_wb          = (r_state == S_EXEC) & ~r_illegal & alu_we;

  // Operands come from the pre-edge register contents; a same-edge writeback is bypassed only when built.
  always_comb begin
    w_opa = r_regs[req.req_sa];
    w_opb = r_regs[req.req_sb];
`ifdef BACK_TO_BACK_EN
    if (w_wb && (req.req_sa == r_dst)) w_opa = alu_r;
    if (w_wb && (req.req_sb == r_dst)) w_opb = alu_r;
`endif
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // NOTE: the register file is small and must read as zero after reset, so it is flops with an explicit reset loop, not a RAM.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
    end else begin
      if (ld_en) r_regs[ld_idx] <= ld_data;
      // Later assignment wins, so a colliding writeback overrides the host load.
      if (w_wb)  r_regs[r_dst]  <= alu_r;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_alu_a      <= '0;
      r_alu_b      <= '0;
      r_alu_n      <= '0;
      r_dst        <= '0;
      r_illegal    <= 1'b0;
      r_done_valid <= 1'b0;
      r_done_r     <= '0;
      r_done_err   <= 1'b0;
      r_cc_q       <= '0;
    end else begin
      r_done_valid <= 1'b0;
      if (r_state == S_EXEC) begin
        r_done_valid <= 1'b1;
        if (r_illegal) begin
          r_done_r   <= '0;
          r_done_err <= 1'b1;
        end else begin
          r_done_r   <= alu_r;
          r_done_err <= 1'b0;
          r_cc_q     <= alu_cc;
        end
      end
      if (w_accept) begin
        r_alu_a   <= w_opa;
        r_alu_b   <= w_opb;
        r_alu_n   <= req.req_op;
        r_dst     <= req.req_dst;
        r_illegal <= req.req_op[3];
      end
    end
  end

  assign rd_data    = r_regs[rd_idx];
  assign alu_a      = r_alu_a;
  assign alu_b      = r_alu_b;
  assign alu_n      = r_alu_n;
  assign done_valid = r_done_valid;
  assign done_r     = r_done_r;
  assign done_err   = r_done_err;
  assign cc_q       = r_cc_q;

endmodule

// File: tb/tb_alu_op_issuer.sv
// Self-checking bench for alu_op_issuer: behavioural ALU, reference register model and a done-event scoreboard.
// Honours BACK_TO_BACK_EN the same way as the design.
module tb_alu_op_issuer;
  localparam int NREGS = 4;
  localparam int IDX_W = 2;

  logic             clk = 1'b0;
  logic             reset;
  logic             ld_en;
  logic [IDX_W-1:0] ld_idx;
  logic [7:0]       ld_data;
  logic [IDX_W-1:0] rd_idx;
  logic [7:0]       rd_data;
  logic [7:0]       alu_a, alu_b, alu_r, done_r;
  logic [3:0]       alu_n, alu_cc, cc_q;
  logic             alu_we, done_valid, done_err;

  always #5 clk = ~clk;

  alu_op_issuer_if #(.IDX_W(IDX_W)) rq ();

  alu_op_issuer #(.NREGS(NREGS), .IDX_W(IDX_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (rq),
    .ld_en      (ld_en),
    .ld_idx     (ld_idx),
    .ld_data    (ld_data),
    .rd_idx     (rd_idx),
    .rd_data    (rd_data),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_n      (alu_n),
    .alu_r      (alu_r),
    .alu_cc     (alu_cc),
    .alu_we     (alu_we),
    .done_valid (done_valid),
    .done_r     (done_r),
    .done_err   (done_err),
    .cc_q       (cc_q)
  );

  typedef struct packed {
    logic [7:0] r;
    logic [3:0] cc;
    logic       we;
  } alu_res_t;

  typedef struct {
    logic [7:0] r;
    logic       err;
    logic [3:0] cc;
    int         cyc;
  } exp_t;

  // Combinational ALU: cc = {max, min, zero (add/sub), arith}; passA never writes; illegal ops drive junk.
  function automatic alu_res_t alu_f(input logic [3:0] n, input logic [7:0] a, input logic [7:0] b);
    alu_res_t s;
    s.we = (n != 4'd4);
    case (n)
      4'd0:    s.r = a + b;
      4'd1:    s.r = a - b;
      4'd2:    s.r = a << 1;
      4'd3:    s.r = a >> 1;
      4'd4:    s.r = a;
      4'd5:    s.r = b;
      4'd6:    s.r = ($signed(a) > $signed(b)) ? a : b;
      4'd7:    s.r = ($signed(a) < $signed(b)) ? a : b;
      default: s.r = 8'hFF;
    endcase
    if (n[3]) s.cc = 4'hF;
    else      s.cc = {(n == 4'd6), (n == 4'd7), ((n <= 4'd1) && (s.r == 8'h00)), (n <= 4'd1)};
    return s;
  endfunction

  alu_res_t alu_s;
  always_comb alu_s = alu_f(alu_n, alu_a, alu_b);
  assign alu_r  = alu_s.r;
  assign alu_cc = alu_s.cc;
  assign alu_we = alu_s.we;

  int         n_checks = 0;
  int         n_fail   = 0;
  int         cyc      = 0;
  logic [7:0] m_regs [NREGS];
  logic [3:0] m_cc;
  exp_t       sb [$];
  exp_t       mon_e;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reg(input string tag, input int idx, input logic [7:0] exp);
    rd_idx = idx[IDX_W-1:0];
    @(negedge clk);
    #1;
    check(tag, {24'h0, rd_data}, {24'h0, exp});
  endtask

  task automatic check_all_regs(input string tag);
    for (int i = 0; i < NREGS; i++) check_reg(tag, i, m_regs[i]);
  endtask

  task automatic load(input int idx, input logic [7:0] data);
    ld_en   = 1'b1;
    ld_idx  = idx[IDX_W-1:0];
    ld_data = data;
    m_regs[idx] = data;
    step();
    ld_en   = 1'b0;
  endtask

  // Returns right after the accept edge, i.e. while the op is in EXEC.
  task automatic issue(input logic [3:0] op, input int sa, input int sb_i, input int dst);
    exp_t     e;
    alu_res_t s;
    int       n;
    n = 0;
    while (rq.req_ready !== 1'b1 && n < 8) begin
      step();
      n++;
    end
    check("ready_wait", {31'h0, (n < 8)}, 32'h1);
    rq.req_valid = 1'b1;
    rq.req_op    = op;
    rq.req_sa    = sa[IDX_W-1:0];
    rq.req_sb    = sb_i[IDX_W-1:0];
    rq.req_dst   = dst[IDX_W-1:0];
    s     = alu_f(op, m_regs[sa], m_regs[sb_i]);
    e.err = op[3];
    e.r   = op[3] ? 8'h00 : s.r;
    e.cc  = op[3] ? m_cc : s.cc;
    e.cyc = cyc + 2;
    if (!op[3]) begin
      m_cc = s.cc;
      if (s.we) m_regs[dst] = s.r;
    end
    sb.push_back(e);
    step();
    rq.req_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    if (reset === 1'b0 && done_valid === 1'b1) begin
      if (sb.size() == 0) begin
        check("done_without_request", {31'h0, done_valid}, 32'h0);
      end else begin
        mon_e = sb.pop_front();
        check("done_r",       {24'h0, done_r},   {24'h0, mon_e.r});
        check("done_err",     {31'h0, done_err}, {31'h0, mon_e.err});
        check("cc_q",         {28'h0, cc_q},     {28'h0, mon_e.cc});
        check("done_latency", cyc,               mon_e.cyc);
      end
    end
  end

  initial begin
    int n;
    reset        = 1'b1;
    rq.req_valid = 1'b0;
    rq.req_op    = '0;
    rq.req_sa    = '0;
    rq.req_sb    = '0;
    rq.req_dst   = '0;
    ld_en        = 1'b0;
    ld_idx       = '0;
    ld_data      = '0;
    rd_idx       = '0;
    m_cc         = '0;
    for (int i = 0; i < NREGS; i++) m_regs[i] = '0;
    repeat (2) step();

    check("rst_done_valid", {31'h0, done_valid}, 32'h0);
    check("rst_done_r",     {24'h0, done_r},     32'h0);
    check("rst_done_err",   {31'h0, done_err},   32'h0);
    check("rst_cc_q",       {28'h0, cc_q},       32'h0);
    check("rst_alu_a",      {24'h0, alu_a},      32'h0);
    check("rst_alu_b",      {24'h0, alu_b},      32'h0);
    check("rst_alu_n",      {28'h0, alu_n},      32'h0);
    check("rst_ready",      {31'h0, rq.req_ready}, 32'h1);
    check_all_regs("rst_reg");
    reset = 1'b0;
    step();

    // add r0,r1->r2
    load(0, 8'h05);
    load(1, 8'h03);
    issue(4'd0, 0, 1, 2);
    check("t1_alu_n", {28'h0, alu_n}, 32'h0);
    check("t1_alu_a", {24'h0, alu_a}, 32'h05);
    check("t1_alu_b", {24'h0, alu_b}, 32'h03);
`ifndef BACK_TO_BACK_EN
    check("t1_exec_ready", {31'h0, rq.req_ready}, 32'h0);
`endif
    check("t1_no_early_done", {31'h0, done_valid}, 32'h0);
    step();
    check("t1_done_valid", {31'h0, done_valid}, 32'h1);
    check("t1_done_r", {24'h0, done_r}, 32'h08);
    check("t1_cc_q", {28'h0, cc_q}, 32'h1);
    check_reg("t1_r2", 2, 8'h08);
    step();
    check("hold_alu_a", {24'h0, alu_a}, 32'h05);
    check("pulse_once", {31'h0, done_valid}, 32'h0);

    // sub r0,r1->r3 yielding zero
    load(0, 8'h03);
    issue(4'd1, 0, 1, 3);
    step();
    check("t2_done_r", {24'h0, done_r}, 32'h00);
    check("t2_cc_q", {28'h0, cc_q}, 32'h3);
    check_reg("t2_r3", 3, 8'h00);

    // illegal opcode
    issue(4'd9, 0, 1, 2);
    step();
    check("t3_done_err", {31'h0, done_err}, 32'h1);
    check("t3_cc_keep", {28'h0, cc_q}, 32'h3);
    check_all_regs("t3_regs");

    // signed max/min
    load(0, 8'h90);
    load(1, 8'h10);
    issue(4'd6, 0, 1, 0);
    step();
    check("t4_max_r", {24'h0, done_r}, 32'h10);
    check("t4_max_cc", {28'h0, cc_q}, 32'h8);
    issue(4'd7, 0, 1, 0);
    step();
    check("t4_min_r", {24'h0, done_r}, 32'h10);
    check("t4_min_cc", {28'h0, cc_q}, 32'h4);

    // remaining opcodes, including passA with writeEnable low
    issue(4'd2, 1, 0, 2);
    issue(4'd3, 2, 0, 3);
    issue(4'd5, 0, 2, 1);
    issue(4'd4, 1, 0, 3);
    step();
    check_reg("passa_no_write", 3, 8'h10);
    check_all_regs("ops_regs");

    // host load collides with writeback to the same register
    issue(4'd0, 0, 1, 2);
    ld_en   = 1'b1;
    ld_idx  = 2'd2;
    ld_data = 8'hAA;
    step();
    ld_en   = 1'b0;
    check_reg("t5_wb_wins", 2, 8'h30);

    // reset during EXEC aborts the op
    issue(4'd1, 1, 0, 3);
    reset = 1'b1;
    void'(sb.pop_back());
    m_cc = '0;
    for (int i = 0; i < NREGS; i++) m_regs[i] = '0;
    step();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("t5_no_done", {31'h0, done_valid}, 32'h0);
      step();
    end
    check("t5_cc_rst", {28'h0, cc_q}, 32'h0);
    check_all_regs("t5_regs_rst");

    // dependent add chain
    load(0, 8'h01);
    issue(4'd0, 0, 0, 1);
`ifdef BACK_TO_BACK_EN
    check("t6_b2b_ready", {31'h0, rq.req_ready}, 32'h1);
    issue(4'd0, 1, 1, 2);
    check("t6_fwd_alu_a", {24'h0, alu_a}, 32'h02);
`else
    check("t6_exec_ready", {31'h0, rq.req_ready}, 32'h0);
    issue(4'd0, 1, 1, 2);
`endif
    step();
    check("t6_done_r", {24'h0, done_r}, 32'h04);
    check_reg("t6_r2", 2, 8'h04);

    n = 0;
    while (sb.size() != 0 && n < 10) begin
      step();
      n++;
    end
    check("scoreboard_drain", sb.size(), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
